// File: rtl/icache_direct_mapped_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Also holds the saturating counter helper.
package icache_direct_mapped_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } cache_state_t;

  localparam int LINE_W      = 128;
  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 30;
  localparam int LINE_ADDR_W = ADDR_W - 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-port and line-fill bus of the instruction cache.
// master = core/memory side, slave = cache.
interface icache_direct_mapped_if;
  import icache_direct_mapped_pkg::*;

  logic                   proc_read;
  logic [ADDR_W-1:0]      proc_addr;
  logic [WORD_W-1:0]      proc_rdata;
  logic                   proc_stall;
  logic                   mem_read;
  logic [LINE_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]      mem_rdata;
  logic                   mem_ready;

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

endinterface

// File: rtl/icache_tag_array.sv
// Valid bits and tags for each cache line; valids clear asynchronously,
// tags are left unreset. One combinational read port, one write port.
module icache_tag_array #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [NUM_BLOCKS-1:0] valid_r;
  logic [TAG_W-1:0]      tag_r [NUM_BLOCKS];

  // valid bit per line, set on fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NUM_BLOCKS{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // tag storage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: same-cycle hits, stalling
// full-line refills from instruction memory, saturating hit/miss counters.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  icache_direct_mapped_if.slave  bus,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  cache_state_t      state_r, state_s;
  logic [IDX_W-1:0]  fill_idx_r;
  logic [TAG_W-1:0]  fill_tag_r;
  logic              mem_read_r;
  logic [31:0]       hit_cnt_r, miss_cnt_r;

  logic [1:0]        offset_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              line_valid_s;
  logic [TAG_W-1:0]  line_tag_s;
  logic              hit_s, miss_s, fill_s;
  logic [LINE_W-1:0] line_s;

  logic [LINE_W-1:0] data_r [NUM_BLOCKS];

  assign offset_s = bus.proc_addr[1:0];
  assign idx_s    = bus.proc_addr[2+IDX_W-1:2];
  assign tag_s    = bus.proc_addr[ADDR_W-1:2+IDX_W];
  assign fill_s   = (state_r == ALLOC) && bus.mem_ready;

  icache_tag_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .wr_en    (fill_s),
    .wr_idx   (fill_idx_r),
    .wr_tag   (fill_tag_r)
  );

  // next-state and hit/miss decode; lookups only happen in IDLE
  always_comb begin
    state_s = state_r;
    hit_s   = 1'b0;
    miss_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.proc_read) begin
          if (line_valid_s && (line_tag_s == tag_s)) begin
            hit_s = 1'b1;
          end else begin
            miss_s  = 1'b1;
            state_s = ALLOC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ALLOC: begin
        if (bus.mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = ALLOC;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state, fill request and latched fill index/tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mem_read_r <= 1'b0;
      fill_idx_r <= {IDX_W{1'b0}};
      fill_tag_r <= {TAG_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (miss_s) begin
        mem_read_r <= 1'b1;
        fill_idx_r <= idx_s;
        fill_tag_r <= tag_s;
      end else if (fill_s) begin
        mem_read_r <= 1'b0;
      end
    end
  end

  // saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end
      if (miss_s) begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
    end
  end

  // line data storage, written only by a fill into the latched index
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[fill_idx_r] <= bus.mem_rdata;
    end
  end

  assign line_s         = data_r[idx_s];
  assign bus.proc_rdata = hit_s ? line_s[{offset_s, 5'd0} +: WORD_W] : {WORD_W{1'b0}};
  // gated by rst_n so the core is never stalled while the cache is held in reset
  assign bus.proc_stall = rst_n & bus.proc_read & ~hit_s;
  assign bus.mem_read   = mem_read_r;
  assign bus.mem_addr   = {fill_tag_r, fill_idx_r};
  assign hit_cnt        = hit_cnt_r;
  assign miss_cnt       = miss_cnt_r;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: a table of fetches with a
// latency-programmable memory model, plus spurious-ready and reset-mid-fill sequences.
module tb_icache_direct_mapped;

  localparam logic [127:0] LA = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LB = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] LC = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  localparam logic [127:0] LD = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] LE = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
  localparam logic [127:0] LF = 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000;

  typedef struct {
    logic [29:0]  addr;
    int           lat;        // 0 = expected hit, memory never answers
    logic [127:0] line;
    int           exp_stall;
    logic [31:0]  exp_rdata;
    logic [31:0]  exp_hit;
    logic [31:0]  exp_miss;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] hit_cnt, miss_cnt;
  int          n_cmp;
  int          n_bad;
  vec_t        vecs [10];

  icache_direct_mapped_if ifc ();

  icache_direct_mapped dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Drives a fetch, plays memory with the given latency
  // (counted in cycles of mem_read high), returns after the served cycle.
  task automatic fetch(input logic [29:0] addr, input int lat, input logic [127:0] line,
                       output int stalls, output logic [31:0] rdata);
    int  rc;
    bit  done;
    rc     = 0;
    done   = 1'b0;
    stalls = 0;
    rdata  = 32'h0;
    ifc.proc_read = 1'b1;
    ifc.proc_addr = addr;
    ifc.mem_ready = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (!ifc.proc_stall) begin
        done          = 1'b1;
        rdata         = ifc.proc_rdata;
        ifc.mem_ready = 1'b0;
        check("mem_read_low_after_fill", {31'd0, ifc.mem_read}, 32'd0);
        check("mem_read_cycles", rc, lat);
      end else begin
        stalls++;
        if (ifc.mem_read) begin
          rc++;
          check("mem_addr", {4'h0, ifc.mem_addr}, {4'h0, addr[29:2]});
          if (rc == lat) begin
            ifc.mem_ready = 1'b1;
            ifc.mem_rdata = line;
          end else begin
            ifc.mem_ready = 1'b0;
          end
        end else begin
          ifc.mem_ready = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("fetch_done", {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          stalls;
    logic [31:0] rdata;
    fetch(v.addr, v.lat, v.line, stalls, rdata);
    check({tag, "_stall"}, stalls, v.exp_stall);
    check({tag, "_rdata"}, rdata, v.exp_rdata);
    check({tag, "_hit_cnt"}, hit_cnt, v.exp_hit);
    check({tag, "_miss_cnt"}, miss_cnt, v.exp_miss);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{30'h05, 4,  LA, 5,  32'hAAAA0001, 32'd1,  32'd1};  // cold miss
    vecs[1] = '{30'h04, 0,  LA, 0,  32'hAAAA0000, 32'd2,  32'd1};  // line sweep
    vecs[2] = '{30'h05, 0,  LA, 0,  32'hAAAA0001, 32'd3,  32'd1};
    vecs[3] = '{30'h06, 0,  LA, 0,  32'hAAAA0002, 32'd4,  32'd1};
    vecs[4] = '{30'h07, 0,  LA, 0,  32'hAAAA0003, 32'd5,  32'd1};
    vecs[5] = '{30'h25, 2,  LB, 3,  32'hBBBB0001, 32'd6,  32'd2};  // conflict, index 1 tag 1
    vecs[6] = '{30'h05, 10, LA, 11, 32'hAAAA0001, 32'd7,  32'd3};  // evicted, misses again
    vecs[7] = '{30'h1E, 1,  LC, 2,  32'hCCCC0002, 32'd8,  32'd4};  // index 7, latency 1
    vecs[8] = '{30'h1C, 0,  LC, 0,  32'hCCCC0000, 32'd9,  32'd4};
    vecs[9] = '{30'h07, 0,  LA, 0,  32'hAAAA0003, 32'd10, 32'd4};

    // reset with a pending fetch: no stall, everything cleared
    rst_n         = 1'b0;
    ifc.proc_read = 1'b1;
    ifc.proc_addr = 30'h5;
    ifc.mem_ready = 1'b0;
    ifc.mem_rdata = 128'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, ifc.proc_stall}, 32'd0);
    check("rst_mem_read", {31'd0, ifc.mem_read}, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst_n         = 1'b1;
    ifc.proc_read = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // spurious mem_ready while idle must not install a line
    ifc.proc_read = 1'b0;
    ifc.mem_rdata = LD;
    ifc.mem_ready = 1'b1;
    #1;
    check("idle_stall", {31'd0, ifc.proc_stall}, 32'd0);
    check("idle_mem_read", {31'd0, ifc.mem_read}, 32'd0);
    check("idle_rdata", ifc.proc_rdata, 32'h0);
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    #1;
    check("idle_mem_read_after", {31'd0, ifc.mem_read}, 32'd0);
    @(negedge clk);
    run_vec('{30'h08, 3, LD, 4, 32'hDDDD0000, 32'd11, 32'd5}, "after_spurious");

    // reset two cycles into ALLOC, then a late ready that must be ignored
    ifc.proc_read = 1'b1;
    ifc.proc_addr = 30'h45;
    ifc.mem_ready = 1'b0;
    #1;
    check("rf_miss_stall", {31'd0, ifc.proc_stall}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rf_mem_read_before", {31'd0, ifc.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rf_mem_read_drop", {31'd0, ifc.mem_read}, 32'd0);
    check("rf_stall", {31'd0, ifc.proc_stall}, 32'd0);
    check("rf_hit_cnt", hit_cnt, 32'd0);
    check("rf_miss_cnt", miss_cnt, 32'd0);
    ifc.proc_read = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    ifc.mem_rdata = LE;
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    #1;
    check("rf_late_ready_mem_read", {31'd0, ifc.mem_read}, 32'd0);
    @(negedge clk);
    run_vec('{30'h45, 2, LF, 3, 32'hFFFF0001, 32'd1, 32'd1}, "rf_refetch");
    run_vec('{30'h05, 1, LA, 2, 32'hAAAA0001, 32'd2, 32'd2}, "rf_valids_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
